// File: rtl/player_sprite_pkg.sv
// Shared player animation encoding: one-hot code constants and pose type.
// Imported by both the animation FSM and player_sprite_decoder.
package player_sprite_pkg;

    localparam int CODE_W    = 12;
    localparam int NUM_POSES = 6;

    typedef logic [2:0] pose_t;

    localparam logic [CODE_W-1:0] CODE_WR  = 12'h001;
    localparam logic [CODE_W-1:0] CODE_WL  = 12'h002;
    localparam logic [CODE_W-1:0] CODE_RR1 = 12'h004;
    localparam logic [CODE_W-1:0] CODE_RR2 = 12'h008;
    localparam logic [CODE_W-1:0] CODE_RR3 = 12'h010;
    localparam logic [CODE_W-1:0] CODE_RR4 = 12'h020;
    localparam logic [CODE_W-1:0] CODE_RR5 = 12'h040;
    localparam logic [CODE_W-1:0] CODE_RL1 = 12'h080;
    localparam logic [CODE_W-1:0] CODE_RL2 = 12'h100;
    localparam logic [CODE_W-1:0] CODE_RL3 = 12'h200;
    localparam logic [CODE_W-1:0] CODE_RL4 = 12'h400;
    localparam logic [CODE_W-1:0] CODE_RL5 = 12'h800;

endpackage

// File: rtl/sprite_code_decode.sv
// Combinational one-hot check and code-to-pose/mirror decode.
module sprite_code_decode
    import player_sprite_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic              valid,
    output pose_t             pose,
    output logic              mirror
);

    logic [3:0] idx;

    always_comb begin
        valid = $onehot(code);
        idx   = 4'd0;
        for (int i = 0; i < CODE_W; i++)
            if (code[i]) idx = 4'(i);

        // walk codes share the standing pose; run codes map to phases 1-5
        if (idx < 4'd2)      pose = pose_t'(0);
        else if (idx < 4'd7) pose = pose_t'(idx - 4'd1);
        else                 pose = pose_t'(idx - 4'd6);

        mirror = (idx == 4'd1) || (idx >= 4'd7);
    end

endmodule

// File: rtl/player_sprite_decoder.sv
// Filters the animation one-hot code and registers sprite-ROM fetch controls.
// Optional blinking while invulnerable: define PLAYER_SPRITE_BLINK_EN.
module player_sprite_decoder
    import player_sprite_pkg::*;
#(
    parameter int STABLE_FRAMES = 1,
    parameter int FRAME_WORDS   = 1024,
    parameter int ADDR_W        = 13,
    parameter int BLINK_FRAMES  = 4
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [CODE_W-1:0] psprite,
    input  logic              invuln,
    output pose_t             pose,
    output logic              mirror,
    output logic [ADDR_W-1:0] rom_base,
    output logic              visible,
    output logic              frame_changed,
    output logic [7:0]        err_count
);

    logic [CODE_W-1:0] cur_code;
    logic [CODE_W-1:0] cand;
    logic [3:0]        cnt;

    logic              code_valid;
    pose_t             dec_pose;
    logic              dec_mirror;
    logic [3:0]        cnt_next;
    logic              accept;
    logic [ADDR_W-1:0] rom_base_next;

    sprite_code_decode u_decode (
        .code   (psprite),
        .valid  (code_valid),
        .pose   (dec_pose),
        .mirror (dec_mirror)
    );

    always_comb begin
        if (psprite == cand) cnt_next = (cnt == 4'd15) ? cnt : cnt + 4'd1;
        else                 cnt_next = 4'd1;
        accept        = code_valid && (32'(cnt_next) >= STABLE_FRAMES) && (psprite != cur_code);
        rom_base_next = ADDR_W'(32'(dec_pose) * FRAME_WORDS);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cur_code      <= CODE_WR;
            cand          <= CODE_WR;
            cnt           <= 4'd0;
            pose          <= pose_t'(0);
            mirror        <= 1'b0;
            rom_base      <= '0;
            frame_changed <= 1'b0;
            err_count     <= 8'd0;
        end else begin
            frame_changed <= 1'b0;
            if (!code_valid) begin
                // glitch: restart the stability window, keep everything else
                cnt <= 4'd0;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
                cand <= psprite;
                cnt  <= cnt_next;
                if (accept) begin
                    cur_code      <= psprite;
                    pose          <= dec_pose;
                    mirror        <= dec_mirror;
                    rom_base      <= rom_base_next;
                    frame_changed <= 1'b1;
                end
            end
        end
    end

`ifdef PLAYER_SPRITE_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (!invuln) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
            blink_cnt <= '0;
            visible   <= ~visible;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    logic unused_invuln;
    assign unused_invuln = invuln;
    assign visible       = 1'b1;
`endif

endmodule

// File: tb/tb_player_sprite_decoder.sv
// Directed bench: two decoders (stability window 1 and 2) against a run-length model.
module tb_player_sprite_decoder;

    localparam int FW = 1024;
    localparam int BF = 4;

    logic        frame_clk;
    logic        Reset;
    logic [11:0] psprite;
    logic        invuln;

    logic [2:0]  pose_o  [2];
    logic        mir_o   [2];
    logic [12:0] base_o  [2];
    logic        vis_o   [2];
    logic        fc_o    [2];
    logic [7:0]  err_o   [2];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // model state
    int          stable [2] = '{1, 2};
    logic [11:0] acc    [2];
    bit          m_fc   [2];
    logic [11:0] last_p;
    int          run;
    int          m_err;
    int          inv_run;
    bit          m_vis;

    player_sprite_decoder #(.STABLE_FRAMES(1), .FRAME_WORDS(FW), .ADDR_W(13), .BLINK_FRAMES(BF)) u_s1 (
        .frame_clk(frame_clk), .Reset(Reset), .psprite(psprite), .invuln(invuln),
        .pose(pose_o[0]), .mirror(mir_o[0]), .rom_base(base_o[0]), .visible(vis_o[0]),
        .frame_changed(fc_o[0]), .err_count(err_o[0]));

    player_sprite_decoder #(.STABLE_FRAMES(2), .FRAME_WORDS(FW), .ADDR_W(13), .BLINK_FRAMES(BF)) u_s2 (
        .frame_clk(frame_clk), .Reset(Reset), .psprite(psprite), .invuln(invuln),
        .pose(pose_o[1]), .mirror(mir_o[1]), .rom_base(base_o[1]), .visible(vis_o[1]),
        .frame_changed(fc_o[1]), .err_count(err_o[1]));

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic int bit_index(input logic [11:0] c);
        int k = 0;
        for (int i = 0; i < 12; i++) if (c[i]) k = i;
        return k;
    endfunction

    function automatic int pose_of(input logic [11:0] c);
        int k = bit_index(c);
        return (k < 2) ? 0 : (k < 7) ? k - 1 : k - 6;
    endfunction

    function automatic int mirror_of(input logic [11:0] c);
        int k = bit_index(c);
        return (k == 1 || k >= 7) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: length of the current run of identical one-hot samples decides acceptance.
    initial begin
        forever begin
            @(posedge frame_clk or posedge Reset);
            if (Reset) begin
                for (int d = 0; d < 2; d++) begin acc[d] = 12'd1; m_fc[d] = 0; end
                last_p = 12'd1; run = 0; m_err = 0; inv_run = 0; m_vis = 1;
            end else begin
                if ($countones(psprite) != 1) begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    run   = 0;
                    for (int d = 0; d < 2; d++) m_fc[d] = 0;
                end else begin
                    run    = (run > 0 && psprite == last_p) ? run + 1 : 1;
                    last_p = psprite;
                    for (int d = 0; d < 2; d++) begin
                        m_fc[d] = 0;
                        if (run >= stable[d] && psprite != acc[d]) begin
                            acc[d]  = psprite;
                            m_fc[d] = 1;
                        end
                    end
                end
`ifdef PLAYER_SPRITE_BLINK_EN
                if (invuln) begin
                    inv_run++;
                    m_vis = ((inv_run / BF) % 2) == 0;
                end else begin
                    inv_run = 0;
                    m_vis   = 1;
                end
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge frame_clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("s%0d.pose", d), int'(pose_o[d]), pose_of(acc[d]));
                    chk($sformatf("s%0d.mirror", d), int'(mir_o[d]), mirror_of(acc[d]));
                    chk($sformatf("s%0d.rom_base", d), int'(base_o[d]), (pose_of(acc[d]) * FW) % 8192);
                    chk($sformatf("s%0d.frame_changed", d), int'(fc_o[d]), int'(m_fc[d]));
                    chk($sformatf("s%0d.err_count", d), int'(err_o[d]), m_err);
                    chk($sformatf("s%0d.visible", d), int'(vis_o[d]), int'(m_vis));
                end
            end
        end
    end

    task automatic step(input logic [11:0] p, input logic inv = 1'b0);
        psprite = p;
        invuln  = inv;
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    initial begin
        Reset = 1'b1; psprite = 12'd1; invuln = 1'b0;
        repeat (2) @(negedge frame_clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst.pose", int'(pose_o[d]), 0);
            chk("rst.rom_base", int'(base_o[d]), 0);
            chk("rst.visible", int'(vis_o[d]), 1);
            chk("rst.frame_changed", int'(fc_o[d]), 0);
        end
        Reset  = 1'b0;
        chk_en = 1;
        step(12'd1);
        chk("idle.fc", int'(fc_o[0]), 0);

        // back-to-back run phases with a one-frame window
        step(12'd4);  chk("s1.p1", int'(pose_o[0]), 1); chk("s1.b1", int'(base_o[0]), 1024); chk("s1.fc1", int'(fc_o[0]), 1);
        step(12'd8);  chk("s1.p2", int'(pose_o[0]), 2); chk("s1.b2", int'(base_o[0]), 2048); chk("s1.fc2", int'(fc_o[0]), 1);
        step(12'd16); chk("s1.p3", int'(pose_o[0]), 3); chk("s1.b3", int'(base_o[0]), 3072); chk("s1.fc3", int'(fc_o[0]), 1);
        chk("s2.nochg", int'(pose_o[1]), 0);
        step(12'd1); step(12'd1);

        // one-frame glitch never reaches a two-frame window
        step(12'd1); step(12'd128);
        chk("s2.glitch.pose", int'(pose_o[1]), 0); chk("s2.glitch.fc", int'(fc_o[1]), 0);
        step(12'd1); step(12'd1);
        chk("s2.glitch.mirror", int'(mir_o[1]), 0);
        step(12'd2048); chk("s2.rl5.wait", int'(pose_o[1]), 0);
        step(12'd2048);
        chk("s2.rl5.pose", int'(pose_o[1]), 5); chk("s2.rl5.mirror", int'(mir_o[1]), 1);
        chk("s2.rl5.base", int'(base_o[1]), 5120); chk("s2.rl5.fc", int'(fc_o[1]), 1);

        // error counter saturation
        repeat (300) step(12'h003);
        chk("err.sat0", int'(err_o[0]), 255); chk("err.sat1", int'(err_o[1]), 255);
        chk("err.hold.pose", int'(pose_o[1]), 5);
        step(12'd2);
        chk("s1.wl.pose", int'(pose_o[0]), 0); chk("s1.wl.mirror", int'(mir_o[0]), 1);
        step(12'd2);
        chk("s2.wl.pose", int'(pose_o[1]), 0); chk("s2.wl.mirror", int'(mir_o[1]), 1);

        // invalid sample restarts the window
        step(12'd4); step(12'd0); step(12'd4);
        chk("s2.restart.hold", int'(pose_o[1]), 0);
        step(12'd4);
        chk("s2.restart.acc", int'(pose_o[1]), 1);

        // blinking
        for (int i = 1; i <= 14; i++) begin
            step(12'd4, 1'b1);
`ifdef PLAYER_SPRITE_BLINK_EN
            if (i == 3)  chk("blink.e3", int'(vis_o[0]), 1);
            if (i == 4)  chk("blink.e4", int'(vis_o[0]), 0);
            if (i == 8)  chk("blink.e8", int'(vis_o[0]), 1);
            if (i == 14) chk("blink.e14", int'(vis_o[0]), 0);
`else
            if (i == 4)  chk("blink.off", int'(vis_o[0]), 1);
`endif
        end
        step(12'd4, 1'b0);
        chk("blink.drop", int'(vis_o[0]), 1);

        // async reset in the middle of a stability window
        step(12'd64);
        chk("s1.rr5.pose", int'(pose_o[0]), 5);
        #2 Reset = 1'b1;
        #1;
        chk("arst.pose", int'(pose_o[0]), 0); chk("arst.base", int'(base_o[0]), 0);
        chk("arst.fc", int'(fc_o[0]), 0);     chk("arst.err", int'(err_o[1]), 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        step(12'd64);
        chk("s2.arst.nopend", int'(pose_o[1]), 0);
        step(12'd64);
        chk("s2.arst.acc", int'(pose_o[1]), 5);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
